// File: rtl/dram_read_prefetch.sv
// dram_read_prefetch
// Sits behind the DRAM burst reader. A new read burst is requested only when the FIFO can
// take every word of it, because DRAM read data cannot be stalled. Returned words are
// buffered in a first-word-fall-through FIFO and handed to the consumer as a valid/ready
// stream.
//
// Ports
//   clk_i, rst_n             clock, asynchronous active-low reset
//   enable_i                 1 = keep issuing bursts, 0 = stop issuing and drain in-flight data
//   burst_len_o              constant BURST_LEN to the reader
//   next_burst_o             one-cycle burst request pulse
//   burst_done_i             reader idle (1) / busy (0)
//   finish_i                 reader has covered the whole DRAM
//   read_data_i/read_valid_i returned word (no back-pressure)
//   m_data_o/m_valid_o/m_ready_i  output stream, FIFO head
//   fill_o                   FIFO occupancy, 0..2**DEPTH_LOG2
//   overflow_o               sticky: a returned word was dropped
//   all_done_o               finish, nothing outstanding and FIFO empty (registered)
module dram_read_prefetch #(
  parameter int unsigned DATA_WIDTH = 288,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned BURST_LEN  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  enable_i,
  output logic [31:0]           burst_len_o,
  output logic                  next_burst_o,
  input  logic                  burst_done_i,
  input  logic                  finish_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic                  read_valid_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DEPTH_LOG2:0]   fill_o,
  output logic                  overflow_o,
  output logic                  all_done_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 2;
  localparam int unsigned FillW = DEPTH_LOG2 + 1;

  localparam logic [CntW-1:0]       BurstCnt  = CntW'(BURST_LEN);
  localparam logic [CntW-1:0]       DepthCnt  = CntW'(Depth);
  localparam logic [CntW-1:0]       CntOne    = CntW'(1);
  localparam logic [FillW-1:0]      DepthFill = FillW'(Depth);
  localparam logic [FillW-1:0]      FillOne   = FillW'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StIssue,
    StWaitAck,
    StWaitBurst
  } state_e;

  state_e state_q;
  logic   next_burst_q;

  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [CntW-1:0]       used;
  logic                  credit_ok;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]      fill_q, fill_d;
  logic                  full, pop, push_ok;
  logic                  overflow_q, all_done_q;

  // Space still free once every requested word has landed; kept in a wider width so the
  // comparison can never wrap.
  assign used      = CntW'(fill_q) + outstanding_q;
  assign credit_ok = (used <= DepthCnt) && ((DepthCnt - used) >= BurstCnt);

  // Burst request FSM. next_burst_q is high exactly while the state is StIssue.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      next_burst_q <= 1'b0;
    end else begin
      next_burst_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable_i && !finish_i) state_q <= StWaitSpace;
        end
        StWaitSpace: begin
          if (!enable_i || finish_i) begin
            state_q <= StIdle;
          end else if (credit_ok && burst_done_i) begin
            state_q      <= StIssue;
            next_burst_q <= 1'b1;
          end
        end
        StIssue: state_q <= StWaitAck;
        StWaitAck: begin
          // A finished reader never acknowledges, so do not wait for it.
          if (finish_i)           state_q <= StWaitSpace;
          else if (!burst_done_i) state_q <= StWaitBurst;
        end
        StWaitBurst: begin
          if (burst_done_i) state_q <= StWaitSpace;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Words requested but not yet returned; surplus words leave it pinned at zero.
  always_comb begin
    outstanding_d = outstanding_q;
    if (state_q == StIssue) begin
      outstanding_d = outstanding_q + BurstCnt - CntW'(read_valid_i);
    end else if (read_valid_i && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CntOne;
    end
  end

  // FIFO control. A pop frees the slot the push needs, so full & push & pop is lossless.
  assign full    = (fill_q == DepthFill);
  assign pop     = (fill_q != '0) && m_ready_i;
  assign push_ok = read_valid_i && (!full || pop);

  always_comb begin
    fill_d = fill_q;
    if (push_ok && !pop)      fill_d = fill_q + FillOne;
    else if (!push_ok && pop) fill_d = fill_q - FillOne;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      overflow_q    <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      fill_q        <= fill_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
      if (read_valid_i && full && !pop) overflow_q <= 1'b1;
      all_done_q <= finish_i && (outstanding_q == '0) && (fill_q == '0);
    end
  end

  // Storage has no reset; only words below fill are ever presented.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= read_data_i;
  end

  assign burst_len_o  = 32'(BURST_LEN);
  assign next_burst_o = next_burst_q;
  assign m_data_o     = mem_q[rd_ptr_q];
  assign m_valid_o    = (fill_q != '0);
  assign fill_o       = fill_q;
  assign overflow_o   = overflow_q;
  assign all_done_o   = all_done_q;

endmodule

// File: tb/tb_dram_read_prefetch.sv
// Bench for dram_read_prefetch with a 64-word FIFO: a reader model answers burst pulses,
// a queue-based scoreboard predicts FIFO contents, occupancy, overflow and all_done, and a
// table plus directed sequences cover the corner cases.
module tb_dram_read_prefetch;

  localparam int DW    = 288;
  localparam int DL    = 6;
  localparam int BL    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, finish, m_ready, burst_done;
  logic [31:0]   burst_len;
  logic          next_burst;
  logic [DW-1:0] read_data, m_data;
  logic          read_valid, m_valid, overflow, all_done;
  logic [DL:0]   fill;

  logic          rdr_valid, man_valid, rdr_busy, rdr_rand;
  logic [DW-1:0] rdr_data, man_data;

  assign read_valid = rdr_valid | man_valid;
  assign read_data  = man_valid ? man_data : rdr_data;

  always #5 clk = ~clk;

  dram_read_prefetch #(
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL),
    .BURST_LEN (BL)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .burst_len_o (burst_len),
    .next_burst_o(next_burst),
    .burst_done_i(burst_done),
    .finish_i    (finish),
    .read_data_i (read_data),
    .read_valid_i(read_valid),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .fill_o      (fill),
    .overflow_o  (overflow),
    .all_done_o  (all_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            out_m = 0;
  bit            ov_m = 0, ad_m = 0;
  int            pulse_cnt = 0, popped = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL m_data: got %h expected %h at %0t", act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic wait_pulses(int target, int budget, string name);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, pulse_cnt, target);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((rdr_busy || !burst_done) && n < budget) begin
      tick(1);
      n++;
    end
    chk("reader_idle", n < budget, 1);
  endtask

  // Reader model: answers each pulse with BL words after a latency.
  initial begin : reader
    int lat;
    burst_done = 1'b1;
    rdr_valid  = 1'b0;
    rdr_data   = '0;
    rdr_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (next_burst && rst_n) begin
        rdr_busy = 1'b1;
        @(posedge clk);
        #1;
        burst_done = 1'b0;
        lat = rdr_rand ? int'($urandom_range(2, 20)) : 14;
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        for (int i = 0; i < BL; i++) begin
          if (!rst_n) break;
          rdr_valid = 1'b1;
          rdr_data  = rand_word();
          @(posedge clk);
          #1;
          rdr_valid = 1'b0;
          if (rdr_rand && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        burst_done = 1'b1;
        rdr_busy   = 1'b0;
      end
    end
  end

  // Scoreboard: compare at negedge, advance the model at posedge.
  initial begin : monitor
    bit issue;
    bit pop;
    int low_run;
    issue   = 1'b0;
    low_run = 99;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        out_m   = 0;
        ov_m    = 1'b0;
        ad_m    = 1'b0;
        low_run = 99;
      end
      chk("fill", fill, q.size());
      chk("m_valid", m_valid, q.size() != 0);
      chk("overflow", overflow, ov_m);
      chk("all_done", all_done, ad_m);
      if (q.size() != 0) chk_data(m_data, q[0]);
      if (next_burst) begin
        chk("pulse_single_cycle", issue, 0);
        chk("pulse_gap_ge2", low_run >= 2, 1);
        chk("credit_at_issue", (q.size() + out_m + BL) <= DEPTH, 1);
        pulse_cnt++;
        low_run = 0;
      end else begin
        low_run++;
      end
      issue = next_burst;
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        out_m = 0;
        ov_m  = 1'b0;
        ad_m  = 1'b0;
      end else begin
        ad_m = finish && (out_m == 0) && (q.size() == 0);
        pop  = (q.size() != 0) && m_ready;
        if (pop) begin
          void'(q.pop_front());
          popped++;
        end
        if (read_valid) begin
          if (q.size() < DEPTH) q.push_back(read_data);
          else ov_m = 1'b1;
        end
        if (issue) out_m = out_m + BL - (read_valid ? 1 : 0);
        else if (read_valid && out_m > 0) out_m--;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  typedef struct {
    bit rv;
    bit rdy;
    int exp_fill;
    bit exp_valid;
  } vec_t;

  initial begin : main
    vec_t tbl[8];
    int   base, pbase, n;

    tbl[0] = '{1'b1, 1'b1, 1, 1'b1};  // empty: pop ignored, push lands
    tbl[1] = '{1'b1, 1'b0, 2, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 2, 1'b1};  // push and pop together
    tbl[3] = '{1'b0, 1'b1, 1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 0, 1'b0};  // pop on empty
    tbl[7] = '{1'b1, 1'b0, 1, 1'b1};

    rst_n = 1'b0; enable = 1'b0; finish = 1'b0; m_ready = 1'b0;
    man_valid = 1'b0; man_data = '0; rdr_rand = 1'b0;
    tick(3);
    chk("rst_fill", fill, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_next_burst", next_burst, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_all_done", all_done, 0);
    chk("burst_len", burst_len, BL);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 8; i++) begin
      man_valid = tbl[i].rv;
      man_data  = rand_word();
      m_ready   = tbl[i].rdy;
      tick(1);
      chk($sformatf("vec%0d_fill", i), fill, tbl[i].exp_fill);
      chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].exp_valid);
    end
    man_valid = 1'b0;
    m_ready   = 1'b1;
    tick(2);
    m_ready   = 1'b0;

    // Single burst, enable dropped while it is in flight
    base = pulse_cnt; pbase = popped;
    m_ready = 1'b1; enable = 1'b1;
    wait_pulses(base + 1, 20, "single_issue");
    enable = 1'b0;
    wait_idle(100);
    tick(10);
    chk("single_pulses", pulse_cnt - base, 1);
    chk("single_words", popped - pbase, BL);
    chk("single_fill", fill, 0);

    // Credit throttle with the consumer stalled
    base = pulse_cnt;
    m_ready = 1'b0; enable = 1'b1;
    wait_pulses(base + 2, 150, "throttle_two");
    wait_idle(100);
    tick(20);
    chk("throttle_pulses", pulse_cnt - base, 2);
    chk("throttle_fill", fill, DEPTH);
    chk("throttle_overflow", overflow, 0);
    m_ready = 1'b1; tick(31); m_ready = 1'b0;
    tick(30);
    chk("throttle_31_pops", pulse_cnt - base, 2);
    m_ready = 1'b1; tick(1); m_ready = 1'b0;
    wait_pulses(base + 3, 20, "throttle_third");
    enable = 1'b0;
    wait_idle(100);
    tick(5);
    chk("refill_fill", fill, DEPTH);
    chk("refill_overflow", overflow, 0);

    // Full FIFO: simultaneous push/pop, then one dropped word
    man_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      man_data = rand_word();
      tick(1);
    end
    chk("full_pp_fill", fill, DEPTH);
    chk("full_pp_overflow", overflow, 0);
    m_ready = 1'b0; man_data = rand_word();
    tick(1);
    man_valid = 1'b0;
    tick(1);
    chk("drop_overflow", overflow, 1);
    chk("drop_fill", fill, DEPTH);
    m_ready = 1'b1; tick(70); m_ready = 1'b0;
    chk("sticky_overflow", overflow, 1);
    chk("drained_fill", fill, 0);

    // Asynchronous reset in the middle of a burst
    base = pulse_cnt;
    enable = 1'b1;
    wait_pulses(base + 1, 20, "rst_burst_issue");
    n = 0;
    while (q.size() < 10 && n < 60) begin
      tick(1);
      n++;
    end
    chk("pre_reset_fill", fill, 10);
    #2;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("async_rst_fill", fill, 0);
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_next_burst", next_burst, 0);
    chk("async_rst_overflow", overflow, 0);
    tick(2);
    rst_n = 1'b1;
    wait_idle(100);
    tick(5);
    chk("post_rst_fill", fill, 0);

    // finish raised while waiting for the reader's acknowledge
    base = pulse_cnt;
    enable = 1'b1; m_ready = 1'b0;
    wait_pulses(base + 1, 20, "finish_issue");
    finish = 1'b1;
    wait_idle(100);
    tick(20);
    chk("finish_no_new_pulse", pulse_cnt - base, 1);
    chk("finish_fill", fill, BL);
    chk("finish_not_done", all_done, 0);
    m_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      tick(1);
      n++;
    end
    chk("last_pop_all_done", all_done, 0);
    tick(1);
    chk("all_done_after_pop", all_done, 1);
    finish = 1'b0; enable = 1'b0; m_ready = 1'b0;
    tick(3);
    chk("all_done_cleared", all_done, 0);

    // Random back-pressure over eight bursts
    rdr_rand = 1'b1;
    base = pulse_cnt; pbase = popped;
    enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (pulse_cnt - base >= 8) enable = 1'b0;
      if (pulse_cnt - base >= 8 && !rdr_busy && burst_done && q.size() == 0) break;
      tick(1);
    end
    m_ready = 1'b0;
    tick(10);
    chk("rand_pulses", pulse_cnt - base, 8);
    chk("rand_words", popped - pbase, 8 * BL);
    chk("rand_overflow", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
